// File: rtl/moore_seq_detector_pkg.sv
// seq_det_pkg: elaboration-time helpers that derive the detector's failure and transition tables
// from the pattern, so the hardware is just a constant lookup.
package seq_det_pkg;

    localparam int MAX_LEN = 16;

    typedef enum logic {
        MODE_RESTART = 1'b0,
        MODE_OVERLAP = 1'b1
    } mode_e;

    function automatic int state_w(input int len);
        return $clog2(len + 1);
    endfunction

    // Longest proper prefix of the first i received bits that is also their suffix.
    function automatic int fail_len(input logic [MAX_LEN-1:0] pattern, input int len, input int i);
        int f;
        logic ok;
        f = 0;
        for (int k = 1; k < MAX_LEN; k++) begin
            ok = (k < i) && (i <= len);
            for (int j = 0; j < MAX_LEN; j++)
                if (ok && j < k && pattern[j] != pattern[i - k + j]) ok = 1'b0;
            if (ok) f = k;
        end
        return f;
    endfunction

    function automatic int next_state(input logic [MAX_LEN-1:0] pattern, input int len,
                                      input int s, input logic x);
        int i;
        int n;
        logic done;
        i = s;
        n = 0;
        done = 1'b0;
        for (int t = 0; t <= MAX_LEN; t++) begin
            if (!done) begin
                if (i < len && x == pattern[i]) begin
                    n = i + 1;
                    done = 1'b1;
                end else if (i == 0) begin
                    done = 1'b1;
                end else begin
                    i = fail_len(pattern, len, i);
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// moore_seq_detector_if: serial sample/control inputs and match/debug outputs of the detector.
interface moore_seq_detector_if
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 5,
    parameter int CNT_W   = 8
);
    localparam int SW = state_w(PAT_LEN);

    logic             en;
    logic             x;
    logic             overlap;
    logic             clr_cnt;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic [SW-1:0]    state;

    modport master (output en, x, overlap, clr_cnt, input z, match_cnt, state);
    modport slave  (input en, x, overlap, clr_cnt, output z, match_cnt, state);

endinterface

// File: rtl/moore_seq_detector_sat_counter.sv
// sat_counter: saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else count <= clr ? '0 : (inc && count != '1) ? count + 1'b1 : count;
    end

endmodule

// File: rtl/moore_seq_detector.sv
// moore_seq_detector: Moore serial pattern detector with run-time overlap select and match counter.
// Transitions come from a table built at elaboration; z decodes only the state register.
module moore_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b01101,
    parameter int                 CNT_W   = 8
) (
    input logic                 clk,
    input logic                 reset,
    moore_seq_detector_if.slave bus
);

    localparam int                 SW      = state_w(PAT_LEN);
    localparam logic [MAX_LEN-1:0] PAT     = MAX_LEN'(PATTERN);
    localparam logic [SW-1:0]      S_MATCH = SW'(PAT_LEN);
    localparam logic [SW-1:0]      F_MATCH = SW'(fail_len(PAT, PAT_LEN, PAT_LEN));

    logic [SW-1:0]    tbl [PAT_LEN][2];
    logic [SW-1:0]    state;
    logic [SW-1:0]    nxt;
    logic [SW-1:0]    base;
    logic [CNT_W-1:0] cnt;
    mode_e            mode;

    for (genvar s = 0; s < PAT_LEN; s++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_col
            assign tbl[s][b] = SW'(next_state(PAT, PAT_LEN, s, 1'(b)));
        end
    end

    assign mode = mode_e'(bus.overlap);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= '0;
        else state <= nxt;
    end

    // Leaving the match state first falls back to the overlap base, then takes a normal step.
    always_comb begin
        base = (state == S_MATCH) ? ((mode == MODE_OVERLAP) ? F_MATCH : '0) : state;
        nxt  = bus.en ? tbl[base][bus.x] : state;
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.en && nxt == S_MATCH),
        .clr   (bus.clr_cnt),
        .count (cnt)
    );

    assign bus.z         = (state == S_MATCH);
    assign bus.state     = state;
    assign bus.match_cnt = cnt;

endmodule
